mem_stage: RTL
==============

# mem_stage

Memory-access stage of the 16-bit five-stage pipeline. Consumes the packed 38-bit EX/MEM register, performs loads and stores on the data memory through a variable-latency req/ack port, and produces the registered MEM/WB write-back fields. While an access is outstanding it stalls the upstream pipeline, and it aborts accesses that exceed a timeout.

## Interface
- TIMEOUT, 16: maximum WAIT cycles without dmem_ack before abort; legal range 1..255.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- ex_mem_bus  in  38  packed EX/MEM register; field layout in Operation.
- stall  out  1  upstream must hold ex_mem_bus (freeze EX/MEM and earlier) while high; combinational.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_addr  out  16  word address; valid while dmem_req.
- dmem_wdata  out  16  store data; valid while dmem_req.
- dmem_ack  in  1  one-cycle completion pulse; ignored unless dmem_req is high.
- dmem_rdata  in  16  load data, sampled in the dmem_ack cycle.
- wb_en  out  1  MEM/WB register-write enable, registered.
- wb_dest  out  3  MEM/WB destination register, registered.
- wb_data  out  16  MEM/WB write data, registered.
- mem_error  out  1  sticky timeout flag; cleared only by reset.
- stall_count  out  16  cycles with stall high, saturating at 16'hFFFF.

## Operation
- Bus fields: [37:22] alu_result (address or ALU value); [21] mem_write_en; [20:5] mem_write_data; [4] write_back_en; [3:1] write_back_dest; [0] write_back_result_mux (1 = memory data, 0 = alu_result). An all-zero bus is a bubble.
- is_store = bit21; is_load = bit4 & bit0 & ~bit21; is_mem = is_store | is_load. A bus with bit0=1 and bit4=0 is treated as a non-memory op.
- FSM states are IDLE and WAIT.
- IDLE, non-memory op: no stall. At the clock edge, wb_en<=bit4, wb_dest<=bits[3:1], wb_data<=alu_result.
- IDLE, is_mem: stall=1 this cycle, and a bubble is written to MEM/WB (wb_en<=0, wb_dest<=0, wb_data<=0). At the edge: dmem_req<=1, dmem_we<=is_store, dmem_addr<=alu_result, dmem_wdata<=mem_write_data; the bit4, dest, and load flag are latched internally; timeout counter<=0; go to WAIT.
- WAIT: dmem_req and its address, write enable, and data stay stable until completion. stall = ~(dmem_ack | timeout_hit), where timeout_hit = (counter == TIMEOUT-1) & ~dmem_ack. The counter increments each WAIT cycle without ack.
- WAIT with ack: dmem_req<=0 and state<=IDLE. For a load: wb_en<=1, wb_dest<=latched dest, wb_data<=dmem_rdata. For a store: wb_en<=latched bit4, wb_data<=latched alu_result. The upstream pipeline advances on this same edge.
- WAIT with timeout_hit: dmem_req<=0, state<=IDLE, mem_error<=1, and a bubble is written to MEM/WB (the access is squashed).
- ack and timeout in the same cycle: ack wins, and mem_error is unchanged.
- dmem_ack while in IDLE: ignored.
- stall_count increments every cycle stall=1 and holds at 16'hFFFF.

## Timing
- Reset values (edge with reset=1): state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_en, wb_dest, wb_data, mem_error, stall_count, and the counter all 0. stall reads 0 after reset when the bus is a bubble.
- Reset during WAIT abandons the access: dmem_req is 0 after that edge, no write-back occurs, and the memory must tolerate the dropped request.
- Non-memory op latency: 1 cycle from bus valid to MEM/WB update.
- Memory op latency: decode cycle C0 (stall=1, dmem_req=0), then dmem_req high from C1. If ack arrives in cycle Ck, MEM/WB is updated at the end of Ck. Minimum is 2 cycles (ack in C1).
- Timeout: with no ack, req is dropped after the edge ending WAIT cycle TIMEOUT, and stall is low in that final cycle.
- Back-to-back memory ops: each op pays its own decode cycle; there is no overlap.

## Test plan
- Non-memory op: bus alu_result=16'h1234, bit4=1, dest=3, bit0=0 -> one cycle later wb_en=1, wb_dest=3, wb_data=16'h1234, with stall never asserted.
- Load with ack at C3: alu_result=16'h0040, bit4=1, bit0=1, dest=5, dmem_rdata=16'hBEEF -> dmem_req=1, dmem_we=0, dmem_addr=16'h0040 during C1–C3; stall=1 in C0–C2 and 0 in C3; after C3 wb_en=1, wb_dest=5, wb_data=16'hBEEF.
- Store with immediate ack: bit21=1, alu_result=16'h0010, data=16'hA5A5, bit4=0 -> dmem_we=1, dmem_wdata=16'hA5A5 in C1; after C1 wb_en=0, stall_count=1.
- Timeout with TIMEOUT=4 and no ack: load -> dmem_req high for exactly 4 cycles, then mem_error=1 and wb_en=0; a later op proceeds normally and mem_error stays 1.
- Ack and timeout in the same cycle (ack in the final WAIT cycle): load completes with rdata written back and mem_error=0.
- Reset asserted in C2 of a pending load -> after that edge, dmem_req=0, all outputs 0, state IDLE; a late dmem_ack pulse is ignored.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory port of the memory-access stage: a registered request held stable
// until a one-cycle ack pulse completes it.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the 16-bit five-stage pipeline: decodes EX/MEM, runs
// loads/stores over a req/ack port with timeout, and registers MEM/WB.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [37:0] ex_mem_bus,
  output logic        stall,
  mem_stage_if.master dmem,
  output logic        wb_en,
  output logic [2:0]  wb_dest,
  output logic [15:0] wb_data,
  output logic        mem_error,
  output logic [15:0] stall_count
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_n;
  logic [7:0]  wait_cnt;
  logic        timeout_hit;
  logic        ack_vld;

  logic [15:0] alu_result_p0;
  logic        is_store_p0, is_load_p0, is_mem_p0;
  logic        wbe_p1, load_p1;
  logic [2:0]  dest_p1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign alu_result_p0 = ex_mem_bus[37:22];
  assign is_store_p0   = ex_mem_bus[21];
  assign is_load_p0    = ex_mem_bus[4] & ex_mem_bus[0] & ~ex_mem_bus[21];
  assign is_mem_p0     = is_store_p0 | is_load_p0;
  assign ack_vld       = dmem.dmem_ack & dmem.dmem_req;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    stall       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem_p0) begin
          stall   = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        timeout_hit = (wait_cnt == TO_LAST) & ~ack_vld;
        stall       = ~(ack_vld | timeout_hit);
        if (ack_vld | timeout_hit) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Decode -> request / write-back boundary
  always_ff @(posedge clock) begin
    if (reset) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 16'd0;
      dmem.dmem_wdata <= 16'd0;
      wb_en           <= 1'b0;
      wb_dest         <= 3'd0;
      wb_data         <= 16'd0;
      mem_error       <= 1'b0;
      wait_cnt        <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem_p0) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= is_store_p0;
            dmem.dmem_addr  <= alu_result_p0;
            dmem.dmem_wdata <= ex_mem_bus[20:5];
            wait_cnt        <= 8'd0;
            wb_en           <= 1'b0;
            wb_dest         <= 3'd0;
            wb_data         <= 16'd0;
          end else begin
            wb_en   <= ex_mem_bus[4];
            wb_dest <= ex_mem_bus[3:1];
            wb_data <= alu_result_p0;
          end
        end
        WAIT: begin
          if (ack_vld) begin
            dmem.dmem_req <= 1'b0;
            wb_dest       <= dest_p1;
            if (load_p1) begin
              wb_en   <= 1'b1;
              wb_data <= dmem.dmem_rdata;
            end else begin
              // the held address is the store's alu_result
              wb_en   <= wbe_p1;
              wb_data <= dmem.dmem_addr;
            end
          end else if (timeout_hit) begin
            dmem.dmem_req <= 1'b0;
            mem_error     <= 1'b1;
            wb_en         <= 1'b0;
            wb_dest       <= 3'd0;
            wb_data       <= 16'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && is_mem_p0) begin
      wbe_p1  <= ex_mem_bus[4];
      dest_p1 <= ex_mem_bus[3:1];
      load_p1 <= is_load_p0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)      stall_count <= 16'd0;
    else if (stall) stall_count <= sat_inc(stall_count);
  end

endmodule
